backoff_mac_scheduler: RTL and testbench

Random-access MAC controller for the OFDM backscatter tag. It owns the tag's `mac_control_signal`, which the top level ANDs with `trigger_signal` before the modulator. Per pending packet it draws a random slot count, counts excitation triggers, and opens the gate for exactly one trigger. It then waits for an ACK and retries with binary exponential backoff, up to a retry limit.

---
 rtl/backoff_mac_scheduler_pkg.sv | 25 ++
 rtl/lfsr_prng.sv | 25 ++
 rtl/backoff_mac_scheduler.sv | 176 +++++++++++++++++
 tb/tb_backoff_mac_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backoff_mac_scheduler_pkg.sv
// mac_pkg: shared types and constants for the backscatter tag MAC.
//   state_t     - scheduler FSM states
//   LFSR_TAPS   - Galois feedback mask for the 16-bit PRNG
//   SLOT_W      - width of slot counters and backoff draws
//   lfsr_step() - one Galois LFSR advance
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        BACKOFF,
        ARMED,
        TX,
        WAIT_ACK
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          SLOT_W    = 6;

    // Right-shifting Galois form: the bit shifted out selects the tap XOR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr_prng.sv
// lfsr_prng: free-running 16-bit Galois LFSR, reusable by any tag-side
// randomizer.
//   SEED  - reset value, must be nonzero or the register locks at zero
//   clock - advances on every rising edge
//   reset - asynchronous, active-high; reloads SEED
//   state - current LFSR contents
module lfsr_prng
    import mac_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] state
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/backoff_mac_scheduler.sv
// backoff_mac_scheduler: random-access MAC gate for the backscatter tag.
// Per packet it draws a random slot count, counts excitation triggers,
// opens mac_control_signal for exactly one trigger, then waits for an ACK
// and retries with binary exponential backoff up to MAX_RETRY times.
//   clock, reset        - main clock; asynchronous active-high reset
//   trigger_signal      - excitation/slot trigger (rising edges counted)
//   pkt_valid/pkt_ready - packet handshake; ready only in IDLE
//   tx_done             - end-of-transmission pulse from the modulator
//   ack_signal          - ACK pulse from the reader
//   mac_control_signal  - gate ANDed with trigger_signal upstream
//   tx_success/tx_drop  - one-cycle result pulses
//   retry_count         - attempt index of the current packet
//   slots_left          - remaining backoff slots (debug)
module backoff_mac_scheduler
    import mac_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          CW_MIN_LOG2 = 2,
    parameter int          CW_MAX_LOG2 = 6,
    parameter int          MAX_RETRY   = 4,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           trigger_signal,
    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    input  logic                           tx_done,
    input  logic                           ack_signal,
    output logic                           mac_control_signal,
    output logic                           tx_success,
    output logic                           tx_drop,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_count,
    output logic [SLOT_W-1:0]              slots_left
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int CW_W    = $clog2(CW_MAX_LOG2 + 1);
    localparam int CNT_W   = $clog2(ACK_TIMEOUT);

    // The timeout fires in the cycle whose increment brings the counter to
    // ACK_TIMEOUT-1, so the following DRAW (or the drop pulse) lands exactly
    // ACK_TIMEOUT cycles after the tx_done cycle.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 2);

    state_t               state_reg, state_next;
    logic [CW_W-1:0]      cw_reg, cw_next;
    logic [RETRY_W-1:0]   retry_next;
    logic [SLOT_W-1:0]    slots_next;
    logic [CNT_W-1:0]     ack_cnt_reg, ack_cnt_next;
    logic                 success_next, drop_next;
    logic                 mac_next, ready_next;
    logic                 trig_q_reg, trig_d_reg, trig_rise;
    logic [15:0]          lfsr_value;
    logic [SLOT_W-1:0]    cw_mask, draw;
    logic                 unused_lfsr_bits;

    lfsr_prng #(
        .SEED (LFSR_SEED)
    ) u_prng (
        .clock (clock),
        .reset (reset),
        .state (lfsr_value)
    );

    // Only the low slot bits feed the draw.
    assign unused_lfsr_bits = ^lfsr_value[15:SLOT_W];

    // Window mask (1<<cw)-1 built bitwise: bit gi is set when gi < cw.
    generate
        for (genvar gi = 0; gi < SLOT_W; gi++) begin : g_cw_mask
            assign cw_mask[gi] = (cw_reg > CW_W'(gi));
        end
    endgenerate

    assign draw = lfsr_value[SLOT_W-1:0] & cw_mask;

    // trigger_signal is sampled once before edge detection, so a rise seen
    // on the pin in cycle n is acted on at the edge closing cycle n+1.
    assign trig_rise = trig_q_reg & ~trig_d_reg;

    always_comb begin
        state_next   = state_reg;
        cw_next      = cw_reg;
        retry_next   = retry_count;
        slots_next   = slots_left;
        ack_cnt_next = ack_cnt_reg;
        success_next = 1'b0;
        drop_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pkt_valid) begin
                    cw_next    = CW_W'(CW_MIN_LOG2);
                    retry_next = '0;
                    state_next = DRAW;
                end
            end
            DRAW: begin
                slots_next = draw;
                state_next = BACKOFF;
            end
            BACKOFF: begin
                if (slots_left == '0) begin
                    state_next = ARMED;
                end else if (trig_rise) begin
                    slots_next = slots_left - 1'b1;
                end
            end
            ARMED: begin
                if (trig_rise) begin
                    state_next = TX;
                end
            end
            TX: begin
                if (tx_done) begin
                    ack_cnt_next = '0;
                    state_next   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                ack_cnt_next = ack_cnt_reg + 1'b1;
                // ACK has priority over a coincident timeout.
                if (ack_signal) begin
                    success_next = 1'b1;
                    state_next   = IDLE;
                end else if (ack_cnt_reg == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_W'(MAX_RETRY)) begin
                        drop_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        retry_next = retry_count + 1'b1;
                        cw_next    = (cw_reg < CW_W'(CW_MAX_LOG2)) ? cw_reg + 1'b1 : cw_reg;
                        state_next = DRAW;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Gate and ready are loaded from the next-state decode so they track
    // the state register cycle for cycle while still being flops.
    assign mac_next   = (state_next == ARMED) || (state_next == TX);
    assign ready_next = (state_next == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            cw_reg             <= CW_W'(CW_MIN_LOG2);
            retry_count        <= '0;
            slots_left         <= '0;
            ack_cnt_reg        <= '0;
            trig_q_reg         <= 1'b0;
            trig_d_reg         <= 1'b0;
            mac_control_signal <= 1'b0;
            pkt_ready          <= 1'b1;
            tx_success         <= 1'b0;
            tx_drop            <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cw_reg             <= cw_next;
            retry_count        <= retry_next;
            slots_left         <= slots_next;
            ack_cnt_reg        <= ack_cnt_next;
            trig_q_reg         <= trigger_signal;
            trig_d_reg         <= trig_q_reg;
            mac_control_signal <= mac_next;
            pkt_ready          <= ready_next;
            tx_success         <= success_next;
            tx_drop            <= drop_next;
        end
    end

endmodule

// File: tb/tb_backoff_mac_scheduler.sv
// Self-checking bench for backoff_mac_scheduler. Inputs are driven and
// outputs sampled on the falling clock edge; expected backoff draws come
// from an independent LFSR model and flow through a scoreboard queue.
module tb_backoff_mac_scheduler;

    localparam logic [15:0] SEED     = 16'hACE1;
    localparam int          ACK_TO   = 64;
    localparam int          MAXR     = 4;
    localparam int          TRIG_W   = 8;
    localparam int          TRIG_GAP = 30;
    localparam int          MAX_TRIG = 70;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger_signal = 1'b0;
    logic       pkt_valid = 1'b0;
    logic       tx_done = 1'b0;
    logic       ack_signal = 1'b0;
    logic       pkt_ready, mac_control_signal, tx_success, tx_drop;
    logic [2:0] retry_count;
    logic [5:0] slots_left;

    int n_cmp = 0;
    int n_bad = 0;
    int succ_cnt = 0;
    int drop_cnt = 0;
    int exp_draw_q[$];
    logic [15:0] model_lfsr;

    backoff_mac_scheduler dut (
        .clock              (clock),
        .reset              (reset),
        .trigger_signal     (trigger_signal),
        .pkt_valid          (pkt_valid),
        .pkt_ready          (pkt_ready),
        .tx_done            (tx_done),
        .ack_signal         (ack_signal),
        .mac_control_signal (mac_control_signal),
        .tx_success         (tx_success),
        .tx_drop            (tx_drop),
        .retry_count        (retry_count),
        .slots_left         (slots_left)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) model_lfsr <= SEED;
        else       model_lfsr <= step(model_lfsr);
    end

    // Pulses of the previous cycle are visible here before this edge's updates.
    always @(posedge clock) begin
        if (tx_success === 1'b1) succ_cnt <= succ_cnt + 1;
        if (tx_drop === 1'b1)    drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    // Called at the falling edge of the DRAW cycle: predict, then check.
    task automatic capture_draw(input int cw, output int d);
        int mask, e;
        mask = (1 << cw) - 1;
        d = int'(model_lfsr[5:0]) & mask;
        exp_draw_q.push_back(d);
        n_cmp++;
        if (pkt_ready !== 1'b0) begin
            n_bad++; $display("FAIL draw_ready: pkt_ready=%b required 0", pkt_ready);
        end
        @(negedge clock);
        e = exp_draw_q.pop_front();
        n_cmp++;
        if (slots_left !== 6'(e)) begin
            n_bad++; $display("FAIL draw_value: slots_left=%0d required %0d", slots_left, e);
        end
        n_cmp++;
        if (int'(slots_left) > mask) begin
            n_bad++; $display("FAIL draw_window: slots_left=%0d exceeds %0d", slots_left, mask);
        end
        $display("draw: cw_log2=%0d slots=%0d retry=%0d", cw, slots_left, retry_count);
    endtask

    task automatic accept_pkt(input int cw, output int d);
        @(negedge clock);
        n_cmp++;
        if (pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL accept_ready: pkt_ready=%b required 1", pkt_ready);
        end
        pkt_valid = 1'b1;
        @(negedge clock);
        pkt_valid = 1'b0;
        capture_draw(cw, d);
    endtask

    // Pulse triggers until the gate is open, then send the transmitting
    // trigger. With do_done the task ends one cycle after the tx_done cycle.
    task automatic run_gate(input int exp_trig, input bit do_done);
        int  seen;
        bit  opened;
        seen = 0;
        opened = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < MAX_TRIG && !opened; k++) begin
            if (mac_control_signal === 1'b1) begin
                opened = 1'b1;
            end else begin
                trigger_signal = 1'b1;
                repeat (TRIG_W) @(negedge clock);
                trigger_signal = 1'b0;
                repeat (TRIG_GAP) @(negedge clock);
                seen++;
            end
        end
        n_cmp++;
        if (!opened || seen != exp_trig) begin
            n_bad++; $display("FAIL gate_open: opened=%b after %0d triggers required open after %0d", opened, seen, exp_trig);
        end
        n_cmp++;
        if (slots_left !== 6'd0) begin
            n_bad++; $display("FAIL gate_slots: slots_left=%0d required 0", slots_left);
        end
        trigger_signal = 1'b1;
        repeat (TRIG_W) @(negedge clock);
        trigger_signal = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (mac_control_signal !== 1'b1) begin
            n_bad++; $display("FAIL gate_tx: mac_control_signal=%b required 1", mac_control_signal);
        end
        if (do_done) begin
            tx_done = 1'b1;
            @(negedge clock);
            tx_done = 1'b0;
            n_cmp++;
            if (mac_control_signal !== 1'b0) begin
                n_bad++; $display("FAIL gate_close: mac_control_signal=%b required 0", mac_control_signal);
            end
        end
    endtask

    task automatic test_reset();
        #23 reset = 1'b0;
        #1;
        n_cmp++;
        if ({pkt_ready, mac_control_signal, tx_success, tx_drop} !== 4'b1000 ||
            retry_count !== 3'd0 || slots_left !== 6'd0) begin
            n_bad++; $display("FAIL reset_outputs: ready/mac/succ/drop=%b retry=%0d slots=%0d required 1000/0/0",
                {pkt_ready, mac_control_signal, tx_success, tx_drop}, retry_count, slots_left);
        end
        n_cmp++;
        if (dut.lfsr_value !== SEED) begin
            n_bad++; $display("FAIL reset_lfsr: lfsr=%h required %h", dut.lfsr_value, SEED);
        end
        @(negedge clock);
        n_cmp++;
        if (dut.lfsr_value !== step(SEED)) begin
            n_bad++; $display("FAIL lfsr_first: lfsr=%h required %h", dut.lfsr_value, step(SEED));
        end
        repeat (5) @(negedge clock);
        n_cmp++;
        if (dut.lfsr_value !== model_lfsr) begin
            n_bad++; $display("FAIL lfsr_seq: lfsr=%h required %h", dut.lfsr_value, model_lfsr);
        end
        // Start a packet, then reset in the middle of a cycle.
        pkt_valid = 1'b1;
        @(negedge clock);
        pkt_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (mac_control_signal !== 1'b0 || tx_success !== 1'b0 || tx_drop !== 1'b0 ||
            slots_left !== 6'd0 || retry_count !== 3'd0) begin
            n_bad++; $display("FAIL reset_async: mac=%b succ=%b drop=%b slots=%0d retry=%0d required all 0",
                mac_control_signal, tx_success, tx_drop, slots_left, retry_count);
        end
        #1 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: pkt_ready=%b required 1", pkt_ready);
        end
        n_cmp++;
        if (dut.lfsr_value !== model_lfsr) begin
            n_bad++; $display("FAIL reset_lfsr_seq: lfsr=%h required %h", dut.lfsr_value, model_lfsr);
        end
        $display("reset: checked");
    endtask

    task automatic test_single_success();
        int d, s0, d0;
        s0 = succ_cnt;
        d0 = drop_cnt;
        accept_pkt(2, d);
        run_gate(d, 1'b1);
        repeat (9) @(negedge clock);
        ack_signal = 1'b1;
        @(negedge clock);
        ack_signal = 1'b0;
        n_cmp++;
        if (tx_success !== 1'b1 || retry_count !== 3'd0) begin
            n_bad++; $display("FAIL single_success: tx_success=%b retry=%0d required 1/0", tx_success, retry_count);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (succ_cnt - s0 != 1 || drop_cnt - d0 != 0 || pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_pulses: success=%0d drop=%0d ready=%b required 1/0/1",
                succ_cnt - s0, drop_cnt - d0, pkt_ready);
        end
        $display("single: draw=%0d success", d);
    endtask

    task automatic test_backoff_escalation();
        int d, s0, d0, cw;
        s0 = succ_cnt;
        d0 = drop_cnt;
        accept_pkt(2, d);
        for (int a = 0; a <= MAXR; a++) begin
            run_gate(d, 1'b1);
            repeat (62) @(negedge clock);
            n_cmp++;
            if (tx_drop !== 1'b0 || pkt_ready !== 1'b0) begin
                n_bad++; $display("FAIL esc_early: attempt %0d drop=%b ready=%b at +63 required 0/0", a, tx_drop, pkt_ready);
            end
            @(negedge clock);
            if (a < MAXR) begin
                n_cmp++;
                if (retry_count !== 3'(a + 1)) begin
                    n_bad++; $display("FAIL esc_retry: retry_count=%0d required %0d", retry_count, a + 1);
                end
                cw = (a + 3 > 6) ? 6 : a + 3;
                capture_draw(cw, d);
            end else begin
                n_cmp++;
                if (tx_drop !== 1'b1 || pkt_ready !== 1'b1 || retry_count !== 3'(MAXR)) begin
                    n_bad++; $display("FAIL esc_drop: drop=%b ready=%b retry=%0d required 1/1/%0d",
                        tx_drop, pkt_ready, retry_count, MAXR);
                end
            end
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (drop_cnt - d0 != 1 || succ_cnt - s0 != 0) begin
            n_bad++; $display("FAIL esc_pulses: drop=%0d success=%0d required 1/0", drop_cnt - d0, succ_cnt - s0);
        end
        $display("escalation: dropped after %0d retries", MAXR);
    endtask

    task automatic test_ack_timeout_collision();
        int d;
        accept_pkt(2, d);
        run_gate(d, 1'b1);
        repeat (ACK_TO - 2) @(negedge clock);
        ack_signal = 1'b1;
        @(negedge clock);
        ack_signal = 1'b0;
        n_cmp++;
        if (tx_success !== 1'b1 || tx_drop !== 1'b0 || pkt_ready !== 1'b1 || retry_count !== 3'd0) begin
            n_bad++; $display("FAIL collision: succ=%b drop=%b ready=%b retry=%0d required 1/0/1/0",
                tx_success, tx_drop, pkt_ready, retry_count);
        end
        @(negedge clock);
        n_cmp++;
        if (pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL collision_idle: pkt_ready=%b required 1", pkt_ready);
        end
        $display("collision: ack won");
    endtask

    task automatic test_trigger_held();
        bit found;
        int d;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clock);
            if ((step(model_lfsr) & 16'h0003) == 16'h0003) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL held_search: no draw of 3 found, found=%b required 1", found);
        end
        pkt_valid = 1'b1;
        @(negedge clock);
        pkt_valid = 1'b0;
        capture_draw(2, d);
        n_cmp++;
        if (slots_left !== 6'd3) begin
            n_bad++; $display("FAIL held_start: slots_left=%0d required 3", slots_left);
        end
        trigger_signal = 1'b1;
        repeat (500) @(negedge clock);
        n_cmp++;
        if (slots_left !== 6'd2) begin
            n_bad++; $display("FAIL held_level: slots_left=%0d required 2", slots_left);
        end
        trigger_signal = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (slots_left !== 6'd2 || mac_control_signal !== 1'b0) begin
            n_bad++; $display("FAIL held_release: slots_left=%0d mac=%b required 2/0", slots_left, mac_control_signal);
        end
        $display("held trigger: slots_left=%0d", slots_left);
    endtask

    task automatic test_reset_during_tx();
        int d, s0, d0;
        s0 = succ_cnt;
        d0 = drop_cnt;
        run_gate(2, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (mac_control_signal !== 1'b0 || tx_success !== 1'b0 || tx_drop !== 1'b0) begin
            n_bad++; $display("FAIL tx_reset: mac=%b succ=%b drop=%b required 0/0/0",
                mac_control_signal, tx_success, tx_drop);
        end
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (succ_cnt - s0 != 0 || drop_cnt - d0 != 0 || pkt_ready !== 1'b1) begin
            n_bad++; $display("FAIL tx_reset_pulses: success=%0d drop=%0d ready=%b required 0/0/1",
                succ_cnt - s0, drop_cnt - d0, pkt_ready);
        end
        accept_pkt(2, d);
        run_gate(d, 1'b1);
        repeat (4) @(negedge clock);
        ack_signal = 1'b1;
        @(negedge clock);
        ack_signal = 1'b0;
        n_cmp++;
        if (tx_success !== 1'b1 || retry_count !== 3'd0) begin
            n_bad++; $display("FAIL post_reset_pkt: succ=%b retry=%0d required 1/0", tx_success, retry_count);
        end
        $display("reset during tx: next packet draw=%0d success", d);
    endtask

    initial begin
        test_reset();
        test_single_success();
        test_backoff_escalation();
        test_ack_timeout_collision();
        test_trigger_held();
        test_reset_during_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
